// File: rtl/fb_bram_arbiter.sv
// fb_bram_arbiter
// Shares one single-port frame-buffer BRAM between the display scan-out
// reader and the host command port. Display fetches win by default; a
// saturating starvation counter forces a host grant after STARVE_MAX
// consecutive display grants while the host is waiting. A {valid, owner}
// tag pipeline steers each BRAM read result back to whoever issued it.
//
// Ports
//   CLK, nRESET                         clock, async active-low reset
//   disp_req/addr -> disp_ready         display read command (comb. accept)
//   disp_rvalid/rdata                   display read response (registered)
//   host_req/we/addr/wdata -> host_ready host command (comb. accept)
//   host_rvalid/rdata                   host read response (registered)
//   bram_en/we/addr/wdata               registered BRAM port drive
//   bram_rdata                          BRAM read data, RD_LAT after bram_en
module fb_bram_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ready,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]      starve_cnt;
  logic            host_win;
  logic            rd_issue;
  logic [RD_LAT:0] tag_vld;
  logic [RD_LAT:0] tag_host;

  // Host only beats a requesting display once the display has had its
  // full quota of back-to-back grants.
  assign host_win   = host_req && (!disp_req || (starve_cnt == STARVE_LIM));
  assign host_ready = nRESET && host_win;
  assign disp_ready = nRESET && disp_req && !host_win;

  // Writes enter the tag pipeline as bubbles so they never raise rvalid.
  assign rd_issue = disp_ready || (host_ready && !host_we);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      starve_cnt <= '0;
    end else if (!host_req || host_ready) begin
      starve_cnt <= '0;
    end else if (disp_ready && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bram_en    <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      bram_en <= disp_ready || host_ready;
      bram_we <= host_ready && host_we;
      if (host_ready) begin
        bram_addr  <= host_addr;
        bram_wdata <= host_wdata;
      end else if (disp_ready) begin
        bram_addr  <= disp_addr;
      end
    end
  end

  // Stage 0 lines up with bram_en; stage RD_LAT lines up with bram_rdata.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      tag_vld  <= '0;
      tag_host <= '0;
    end else begin
      tag_vld  <= {tag_vld[RD_LAT-1:0], rd_issue};
      tag_host <= {tag_host[RD_LAT-1:0], host_ready};
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      disp_rvalid <= 1'b0;
      disp_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      disp_rvalid <= tag_vld[RD_LAT] && !tag_host[RD_LAT];
      host_rvalid <= tag_vld[RD_LAT] && tag_host[RD_LAT];
      if (tag_vld[RD_LAT] && !tag_host[RD_LAT]) begin
        disp_rdata <= bram_rdata;
      end
      if (tag_vld[RD_LAT] && tag_host[RD_LAT]) begin
        host_rdata <= bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_bram_arbiter.sv
module tb_fb_bram_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 1;
  localparam int STARVE_MAX = 16;

  logic CLK = 1'b0;
  logic nRESET;
  logic disp_req, disp_ready, disp_rvalid;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic host_req, host_we, host_ready, host_rvalid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata, host_rdata;
  logic bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [DATA_W-1:0] bram_rdata = '0;

  always #5 CLK = ~CLK;

  fb_bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
                    .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ready(disp_ready),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  // BRAM primitive: latency-1 read-first RAM, unwritten words read as addr.
  logic [DATA_W-1:0] bmem [logic [ADDR_W-1:0]];
  always @(posedge CLK) begin
    if (bram_en) begin
      if (bram_we) bmem[bram_addr] = bram_wdata;
      else bram_rdata <= bmem.exists(bram_addr) ? bmem[bram_addr] : bram_addr[DATA_W-1:0];
    end
  end

  // Reference model: memory contents in grant order plus expected responses.
  typedef struct { int due; bit host; logic [DATA_W-1:0] data; } rsp_t;
  rsp_t expq[$];
  logic [DATA_W-1:0] refmem [logic [ADDR_W-1:0]];
  int nvec = 0, nerr = 0, cyc = 0;
  int mcnt;
  bit pg_v, pg_we, d_acc, h_acc;
  logic [ADDR_W-1:0] pg_addr, last_baddr;
  logic [DATA_W-1:0] pg_wdata, last_dd, last_hd;
  int hgrants[$];

  function automatic logic [DATA_W-1:0] refread(input logic [ADDR_W-1:0] a);
    return refmem.exists(a) ? refmem[a] : a[DATA_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    expq.delete();
    mcnt = 0; pg_v = 0; pg_we = 0; pg_addr = '0; pg_wdata = '0;
    last_baddr = '0; last_dd = '0; last_hd = '0; d_acc = 0; h_acc = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_disp_ready"}, disp_ready, 0);
    chk({tag, "_host_ready"}, host_ready, 0);
    chk({tag, "_bram_en"}, bram_en, 0);
    chk({tag, "_bram_we"}, bram_we, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_bram_wdata"}, bram_wdata, 0);
    chk({tag, "_disp_rvalid"}, disp_rvalid, 0);
    chk({tag, "_disp_rdata"}, disp_rdata, 0);
    chk({tag, "_host_rvalid"}, host_rvalid, 0);
    chk({tag, "_host_rdata"}, host_rdata, 0);
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic step();
    bit ehw, edw, edv, ehv;
    rsp_t r;
    #1;
    ehw = host_req && (!disp_req || mcnt == STARVE_MAX);
    edw = disp_req && !ehw;
    chk("disp_ready", disp_ready, edw);
    chk("host_ready", host_ready, ehw);
    chk("ready_excl", disp_ready & host_ready, 0);
    chk("bram_en", bram_en, pg_v);
    chk("bram_we", bram_we, pg_v & pg_we);
    if (pg_v) last_baddr = pg_addr;
    chk("bram_addr", bram_addr, last_baddr);
    if (pg_v && pg_we) chk("bram_wdata", bram_wdata, pg_wdata);
    edv = 0; ehv = 0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      r = expq.pop_front();
      if (r.host) begin ehv = 1; last_hd = r.data; end
      else begin edv = 1; last_dd = r.data; end
    end
    chk("disp_rvalid", disp_rvalid, edv);
    chk("disp_rdata", disp_rdata, last_dd);
    chk("host_rvalid", host_rvalid, ehv);
    chk("host_rdata", host_rdata, last_hd);
    pg_v = edw || ehw;
    pg_we = ehw && host_we;
    pg_addr = ehw ? host_addr : disp_addr;
    pg_wdata = host_wdata;
    if (ehw) hgrants.push_back(cyc);
    if (ehw && host_we) refmem[host_addr] = host_wdata;
    else if (pg_v) begin
      r.due = cyc + RD_LAT + 2; r.host = ehw; r.data = refread(pg_addr);
      expq.push_back(r);
    end
    if (!host_req || ehw) mcnt = 0;
    else if (edw) mcnt = (mcnt + 1 > STARVE_MAX) ? STARVE_MAX : mcnt + 1;
    d_acc = edw; h_acc = ehw;
    @(posedge CLK); cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    disp_req = 0; host_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int s;
    nRESET = 0;
    disp_req = 1; disp_addr = 18'h3; host_req = 1; host_we = 0;
    host_addr = 18'h5; host_wdata = 16'h1234;
    mreset();
    #12;
    chk_all_zero("init_rst");
    @(negedge CLK);
    nRESET = 1;
    idle(2);

    // Display-only stream of 8 reads, addr 0..7.
    for (int i = 0; i < 8; i++) begin
      disp_req = 1; disp_addr = ADDR_W'(i);
      step();
    end
    idle(5);

    // Continuous contention: host must be granted once every 17 cycles.
    hgrants.delete();
    s = cyc;
    host_we = 0; host_addr = 18'h40;
    for (int i = 0; i < 60; i++) begin
      disp_req = 1; disp_addr = ADDR_W'(8 + i);
      host_req = 1;
      if (h_acc) host_addr = host_addr + 1;
      step();
    end
    chk("contend_host_grants", hgrants.size(), 3);
    if (hgrants.size() > 0) chk("contend_first_wait", hgrants[0] - s, STARVE_MAX);
    for (int i = 1; i < hgrants.size(); i++)
      chk("contend_period", hgrants[i] - hgrants[i-1], STARVE_MAX + 1);
    idle(5);

    // Display read before the write sees old data, after it sees new data.
    disp_req = 1; disp_addr = 18'h00100; step();
    disp_req = 0; host_req = 1; host_we = 1; host_addr = 18'h00100;
    host_wdata = 16'hA5A5; step();
    host_req = 0; disp_req = 1; disp_addr = 18'h00100; step();
    idle(5);
    chk("wr_rd_new", disp_rdata, 16'hA5A5);

    // Randomised mixed traffic over a small address window.
    for (int i = 0; i < 300; i++) begin
      if (!disp_req || d_acc) begin
        disp_req = ($urandom_range(0, 3) != 0);
        disp_addr = ADDR_W'($urandom_range(0, 31));
      end
      if (!host_req || h_acc) begin
        host_req = ($urandom_range(0, 2) == 0);
        host_we = 1'($urandom_range(0, 1));
        host_addr = ADDR_W'($urandom_range(0, 31));
        host_wdata = DATA_W'($urandom);
      end
      step();
    end
    idle(5);

    // Reset with two reads in flight.
    disp_req = 1; disp_addr = 18'h3; step();
    disp_req = 1; disp_addr = 18'h4; step();
    host_req = 1; host_we = 0; disp_addr = 18'h5;
    #2 nRESET = 0;
    #1 chk_all_zero("mid_rst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("hold_rst");
    nRESET = 1;
    mreset();
    idle(6);
    disp_req = 1; disp_addr = 18'h7; host_req = 1; host_we = 0; host_addr = 18'h9;
    step();
    disp_req = 0; step();
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
